store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of entries; power of two, at least 2.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 reset_ni  input  1  reset, asynchronous and active-low.
REQ-004 put_enable_i  input  1  MEM-stage request to enqueue a retiring store.
REQ-005 put_addr_i  input  32  store byte address.
REQ-006 put_data_i  input  32  store data, unaligned rs2 value in bits [7:0]/[15:0]/[31:0].
REQ-007 put_size_i  input  cache_access_size_t  store size: BYTE=0, HALF=1, WORD=2.
REQ-008 get_enable_i  input  1  dcache-side request to dequeue the oldest entry.
REQ-009 get_addr_o / get_data_o / get_size_o  output  32/32/cache_access_size_t  oldest entry, with data unaligned as enqueued.
REQ-010 empty_o  output  1  no valid entries.
REQ-011 full_o  output  1  DEPTH valid entries.
REQ-012 snoop_addr_i  input  32  load byte address from MEM stage.
REQ-013 snoop_size_i  input  cache_access_size_t  load size.
REQ-014 snoop_hit_o  output  1  the buffer fully supplies every load byte.
REQ-015 snoop_data_o  output  32  forwarded word, lane-aligned (byte k of the word in bits [8k+7:8k]).
REQ-016 snoop_partial_o  output  1  the load overlaps buffered bytes but cannot be fully forwarded; MEM stage shall stall.

Function
REQ-017 Storage shall be a circular FIFO of DEPTH entries, each {valid, addr, data, size}, with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
REQ-018 A put shall be accepted when put_enable_i=1 and (full_o=0 or (get_enable_i=1 and empty_o=0)); an accepted put writes the tail entry and advances tail by one on the same edge.
REQ-019 A put when full_o=1 and no get is in the same cycle shall be ignored with no state change; the caller is responsible for stalling.
REQ-020 A get shall be accepted when get_enable_i=1 and empty_o=0; it invalidates the head entry and advances head by one; a get when empty shall be ignored.
REQ-021 On a simultaneous accepted put and get, count shall be unchanged; with count=1 the new entry becomes the head after the edge.
REQ-022 get_* outputs shall be combinational from the head entry; when empty they shall be zero.
REQ-023 empty_o = (count==0); full_o = (count==DEPTH); both combinational from registered count.
REQ-024 Byte mask: BYTE gives 1<<a[1:0]; HALF gives 3<<a[1:0]; WORD gives 4'hF. Addresses are assumed naturally aligned by the producer; masks are truncated to 4 bits.
REQ-025 Snoop shall be combinational and shall consider only valid entries with addr[31:2]==snoop_addr_i[31:2] whose mask overlaps the load mask; a put in the same cycle shall not be visible.
REQ-026 Among the overlapping entries, the youngest (closest to tail) shall be selected; if its mask covers the load mask, then snoop_hit_o=1, snoop_partial_o=0, and snoop_data_o = selected data shifted left by 8*addr[1:0], with lanes outside the mask zero.
REQ-027 If any overlapping entry exists but the youngest does not cover the load mask, then snoop_partial_o=1, snoop_hit_o=0, and snoop_data_o=0.
REQ-028 If no entry overlaps, then snoop_hit_o=0, snoop_partial_o=0, and snoop_data_o=0.
REQ-029 snoop_hit_o and snoop_partial_o shall never both be 1.

Reset
REQ-030 While reset_ni=0, all valid bits, head, tail and count shall clear asynchronously; empty_o=1, full_o=0, and all other outputs shall be 0. Entries in flight mid-operation are discarded.
REQ-031 Deassertion shall take effect at the first rising edge after reset_ni=1; no put or get shall be accepted on that edge if reset was still low at that edge.

Verification
REQ-032 Fill and wrap: DEPTH=4, put 5 words A0..A4 -> full_o=1 after 4 puts, the 5th is ignored; 4 gets return A0..A3 in order, then empty_o=1.
REQ-033 Put+get at full: with 4 entries, assert put(X) and get together -> count stays 4, full_o stays 1, and X is returned 4th in order.
REQ-034 Forwarding: SW 0x1000 data 0x11223344, then SB 0x1001 data 0xAA; LBU 0x1001 -> hit, snoop_data_o=0x0000AA00; LW 0x1000 -> partial=1.
REQ-035 Youngest wins: SW 0x2000 0x1, then SW 0x2000 0x2; LW 0x2000 -> hit with data 0x00000002; after one get, still 0x2.
REQ-036 No overlap: SH 0x3000; LH 0x3002 -> hit=0, partial=0, data=0.
REQ-037 Async reset: with 3 entries, pull reset_ni low between edges -> empty_o=1 immediately, and a snoop on buffered addresses gives hit=0.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of retiring stores with youngest-entry
// load forwarding and a partial-overlap stall indication.
package store_buffer_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } cache_access_size_t;
endpackage

module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               put_enable_i,
    input  logic [31:0]        put_addr_i,
    input  logic [31:0]        put_data_i,
    input  cache_access_size_t put_size_i,
    input  logic               get_enable_i,
    output logic [31:0]        get_addr_o,
    output logic [31:0]        get_data_o,
    output cache_access_size_t get_size_o,
    output logic               empty_o,
    output logic               full_o,
    input  logic [31:0]        snoop_addr_i,
    input  cache_access_size_t snoop_size_i,
    output logic               snoop_hit_o,
    output logic [31:0]        snoop_data_o,
    output logic               snoop_partial_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                 valid_q [DEPTH];
    logic [31:0]          addr_q  [DEPTH];
    logic [31:0]          data_q  [DEPTH];
    cache_access_size_t   size_q  [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic put_accept;
    logic get_accept;

    function automatic logic [3:0] byte_mask(input cache_access_size_t sz,
                                             input logic [1:0] off);
        case (sz)
            BYTE:    byte_mask = 4'b0001 << off;
            HALF:    byte_mask = 4'b0011 << off;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign get_accept = get_enable_i && !empty_o;
    // A put into a full buffer is only legal when the head drains on the same edge.
    assign put_accept = put_enable_i && (!full_o || get_accept);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (get_accept) head_d = head_q + PTR_W'(1);
        if (put_accept) tail_d = tail_q + PTR_W'(1);
        if (put_accept && !get_accept) count_d = count_q + CNT_W'(1);
        else if (get_accept && !put_accept) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                size_q[i]  <= BYTE;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (get_accept) valid_q[head_q] <= 1'b0;
            // Put after get: at full, head and tail share a slot and the new entry must win.
            if (put_accept) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= put_addr_i;
                data_q[tail_q]  <= put_data_i;
                size_q[tail_q]  <= put_size_i;
            end
        end
    end

    always_comb begin
        get_addr_o = '0;
        get_data_o = '0;
        get_size_o = BYTE;
        if (!empty_o) begin
            get_addr_o = addr_q[head_q];
            get_data_o = data_q[head_q];
            get_size_o = size_q[head_q];
        end
    end

    logic [3:0]       load_mask;
    logic [3:0]       sel_mask;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] sel_idx;
    logic             sel_found;
    logic [31:0]      lane_bits;
    logic [31:0]      shifted;

    always_comb begin
        load_mask       = byte_mask(snoop_size_i, snoop_addr_i[1:0]);
        idx             = '0;
        sel_idx         = '0;
        sel_found       = 1'b0;
        sel_mask        = '0;
        lane_bits       = '0;
        shifted         = '0;
        snoop_hit_o     = 1'b0;
        snoop_partial_o = 1'b0;
        snoop_data_o    = '0;
        // Walk oldest to youngest so the last overlapping entry found is the youngest.
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx][31:2] == snoop_addr_i[31:2]) &&
                |(byte_mask(size_q[idx], addr_q[idx][1:0]) & load_mask)) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
        if (sel_found) begin
            sel_mask = byte_mask(size_q[sel_idx], addr_q[sel_idx][1:0]);
            if ((sel_mask & load_mask) == load_mask) begin
                for (int k = 0; k < 4; k++) lane_bits[8*k +: 8] = {8{load_mask[k]}};
                shifted      = data_q[sel_idx] << {addr_q[sel_idx][1:0], 3'b000};
                snoop_hit_o  = 1'b1;
                snoop_data_o = shifted & lane_bits;
            end else begin
                snoop_partial_o = 1'b1;
            end
        end
    end
endmodule
